// File: rtl/winograd_seq_if.sv
// Handshake bundle for the winograd job sequencer: job configuration,
// operand chunk stream and result return.
interface winograd_seq_if #(
  parameter int IN_SIZE_0  = 4,
  parameter int IN_SIZE_1  = 8,
  parameter int ARRAY_SIZE = 8,
  parameter int MAX_CHUNKS = 16,
  parameter int ACC_SIZE   = 32
);
  localparam int CW = $clog2(MAX_CHUNKS + 1);

  logic                                 cfg_valid_i;
  logic                                 cfg_ready_o;
  logic [CW-1:0]                        cfg_chunks_i;
  logic [ACC_SIZE-1:0]                  cfg_corr_i;
  logic                                 in_valid_i;
  logic                                 in_ready_o;
  logic [0:ARRAY_SIZE-1][IN_SIZE_0-1:0] in_0_i;
  logic [0:ARRAY_SIZE-1][IN_SIZE_1-1:0] in_1_i;
  logic                                 res_valid_o;
  logic                                 res_ready_i;
  logic [ACC_SIZE-1:0]                  res_data_o;
  logic                                 res_ovf_o;

  modport master (
    output cfg_valid_i, cfg_chunks_i, cfg_corr_i,
    output in_valid_i, in_0_i, in_1_i,
    output res_ready_i,
    input  cfg_ready_o, in_ready_o, res_valid_o, res_data_o, res_ovf_o
  );

  modport slave (
    input  cfg_valid_i, cfg_chunks_i, cfg_corr_i,
    input  in_valid_i, in_0_i, in_1_i,
    input  res_ready_i,
    output cfg_ready_o, in_ready_o, res_valid_o, res_data_o, res_ovf_o
  );
endinterface

// File: rtl/winograd_seq.sv
// Job sequencer for the winograd pair-product datapath: streams operand
// chunks in, tracks pipeline latency with a tag shift register, accumulates.
module winograd_seq #(
  parameter  int IN_SIZE_0  = 4,
  parameter  int IN_SIZE_1  = 8,
  parameter  int ARRAY_SIZE = 8,
  parameter  int DP_LATENCY = 3,
  parameter  int MAX_CHUNKS = 16,
  parameter  int ACC_SIZE   = 32,
  localparam int OUT_SIZE   = 2 * (IN_SIZE_0 + IN_SIZE_1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  winograd_seq_if.slave                        bus,
  output logic [0:ARRAY_SIZE-1][IN_SIZE_0-1:0] dp_in_0_o,
  output logic [0:ARRAY_SIZE-1][IN_SIZE_1-1:0] dp_in_1_o,
  input  logic [0:1][OUT_SIZE-1:0]             dp_out_i
);
  localparam int                    CW       = $clog2(MAX_CHUNKS + 1);
  localparam logic [CW-1:0]         MAX_N    = CW'(MAX_CHUNKS);
  localparam logic [DP_LATENCY-1:0] TAG_LAST = DP_LATENCY'(1) << (DP_LATENCY - 1);
  localparam int                    MSB      = ACC_SIZE - 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;

  state_e                               state_q, state_d;
  logic [CW-1:0]                        rem_q, rem_d;
  logic [DP_LATENCY-1:0]                tag_q, tag_d;
  logic [ACC_SIZE-1:0]                  acc_q, acc_d;
  logic                                 ovf_q, ovf_d;
  logic                                 cfg_ready_q, cfg_ready_d;
  logic                                 in_ready_q, in_ready_d;
  logic                                 res_valid_q, res_valid_d;
  logic [0:ARRAY_SIZE-1][IN_SIZE_0-1:0] dp_in_0_q, dp_in_0_d;
  logic [0:ARRAY_SIZE-1][IN_SIZE_1-1:0] dp_in_1_q, dp_in_1_d;

  logic [CW-1:0]       chunks_s;
  logic                in_hs_s;
  logic [ACC_SIZE-1:0] p0_s, p1_s, sum_a_s, sum_b_s;
  logic                ovf_a_s, ovf_b_s;

  assign chunks_s = (bus.cfg_chunks_i > MAX_N) ? MAX_N : bus.cfg_chunks_i;
  assign in_hs_s  = bus.in_valid_i && in_ready_q;

  // Two chained signed adds; overflow when operands agree in sign but the sum does not.
  assign p0_s    = {{(ACC_SIZE - OUT_SIZE){dp_out_i[0][OUT_SIZE-1]}}, dp_out_i[0]};
  assign p1_s    = {{(ACC_SIZE - OUT_SIZE){dp_out_i[1][OUT_SIZE-1]}}, dp_out_i[1]};
  assign sum_a_s = acc_q + p0_s;
  assign sum_b_s = sum_a_s + p1_s;
  assign ovf_a_s = (acc_q[MSB] == p0_s[MSB]) && (sum_a_s[MSB] != acc_q[MSB]);
  assign ovf_b_s = (sum_a_s[MSB] == p1_s[MSB]) && (sum_b_s[MSB] != sum_a_s[MSB]);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    tag_d     = tag_q << 1;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    dp_in_0_d = dp_in_0_q;
    dp_in_1_d = dp_in_1_q;

    if (tag_q[DP_LATENCY-1]) begin
      acc_d = sum_b_s;
      ovf_d = ovf_q | ovf_a_s | ovf_b_s;
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.cfg_valid_i) begin
          acc_d   = bus.cfg_corr_i;
          rem_d   = chunks_s;
          ovf_d   = 1'b0;
          tag_d   = '0;
          state_d = (chunks_s == '0) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (in_hs_s) begin
          dp_in_0_d = bus.in_0_i;
          dp_in_1_d = bus.in_1_i;
          tag_d[0]  = 1'b1;
          rem_d     = rem_q - CW'(1);
          state_d   = (rem_q == CW'(1)) ? DRAIN : RUN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN:   state_d = (tag_q == TAG_LAST) ? DONE : DRAIN;
      DONE:    state_d = (res_valid_q && bus.res_ready_i) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase

    // Dropping the tags is what makes in-flight datapath results harmless.
    if (clear_i) begin
      state_d = IDLE;
      tag_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
      rem_d   = '0;
    end else begin
      rem_d = rem_d;
    end

    cfg_ready_d = (state_d == IDLE);
    in_ready_d  = (state_d == RUN);
    // A zero-chunk job spends one cycle in DONE before presenting its result.
    res_valid_d = (state_d == DONE) && (state_q != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      tag_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cfg_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      dp_in_0_q   <= '0;
      dp_in_1_q   <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      tag_q       <= tag_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cfg_ready_q <= cfg_ready_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      dp_in_0_q   <= dp_in_0_d;
      dp_in_1_q   <= dp_in_1_d;
    end
  end

  assign bus.cfg_ready_o = cfg_ready_q;
  assign bus.in_ready_o  = in_ready_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_data_o  = acc_q;
  assign bus.res_ovf_o   = ovf_q;
  assign dp_in_0_o       = dp_in_0_q;
  assign dp_in_1_o       = dp_in_1_q;
endmodule

// File: doc/winograd_seq.md
# winograd_seq

Job sequencer for the `winograd` pair-product datapath.
- Accepts a job configuration: chunk count and a precomputed Winograd correction term.
- Streams the job's operand chunks into the datapath with a valid/ready handshake, one chunk per cycle.
- Tracks the datapath's fixed pipeline latency and accumulates both partial-sum outputs into a wide signed accumulator.
- Returns the finished dot product through a result handshake.
- Sits between the operand fetch logic and one `winograd` instance.

## Interface
- `IN_SIZE_0`, 4, signed width of operand set 0.
- `IN_SIZE_1`, 8, signed width of operand set 1.
- `ARRAY_SIZE`, 8, lanes per chunk; must be even.
- `DP_LATENCY`, 3, cycles from datapath input register update to valid `dp_out_i`; must be ≥1.
- `MAX_CHUNKS`, 16, largest allowed `cfg_chunks_i` value.
- `ACC_SIZE`, 32, signed accumulator/result width; must be ≥ OUT_SIZE+1.
- `OUT_SIZE` (localparam), 24 at defaults; same formula as the `winograd` output width.
- `clk_i`  in  1  clock; all state on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `clear_i`  in  1  synchronous abort; priority over all other inputs.
- `cfg_valid_i`  in  1  job request.
- `cfg_ready_o`  out  1  job accepted when high with `cfg_valid_i`.
- `cfg_chunks_i`  in  $clog2(MAX_CHUNKS+1)  chunk count N, from 0 to MAX_CHUNKS.
- `cfg_corr_i`  in  ACC_SIZE  signed initial accumulator value (the correction term).
- `in_valid_i`, `in_ready_o`  in/out  1  chunk handshake.
- `in_0_i`  in  [0:ARRAY_SIZE-1] × IN_SIZE_0  chunk operands, set 0.
- `in_1_i`  in  [0:ARRAY_SIZE-1] × IN_SIZE_1  chunk operands, set 1.
- `dp_in_0_o`, `dp_in_1_o`  out  same shapes as `in_0_i`/`in_1_i`  registered datapath operands.
- `dp_out_i`  in  [0:1] × OUT_SIZE  signed datapath partial sums.
- `res_valid_o`, `res_ready_i`  out/in  1  result handshake.
- `res_data_o`  out  ACC_SIZE  signed result.
- `res_ovf_o`  out  1  sticky signed-overflow flag for the job.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- IDLE:
  - `cfg_ready_o`=1.
  - On handshake: load acc=`cfg_corr_i`, remaining=N, ovf=0, and issued-pipe valid bits=0.
  - Go to RUN if N>0, else to DONE.
- RUN:
  - `in_ready_o`=1.
  - Each in-handshake: register `in_0_i`/`in_1_i` into `dp_in_*_o`, push 1 into the DP_LATENCY-deep tag shift register, and decrement remaining.
  - Cycles without a handshake push 0; `dp_in_*_o` hold their value.
  - Go to DRAIN on the handshake that brings remaining to 0.
- DRAIN: `in_ready_o`=0. Go to DONE on the edge where the last valid tag leaves the shift register.
- Accumulate: on every edge where the shift-register output tag is 1, set acc += sext(`dp_out_i[0]`) + sext(`dp_out_i[1]`), computed in ACC_SIZE bits with wrap-around.
- Overflow: set ovf if either signed add overflows ACC_SIZE bits. It stays set until the next job load.
- DONE:
  - `res_valid_o`=1; `res_data_o`=acc and `res_ovf_o`=ovf, both held stable.
  - On `res_ready_i` go to IDLE.
  - `cfg_ready_o`=0 until the handshake completes; there is no result/config overlap.
- `clear_i`: next state IDLE, shift register zeroed, acc/ovf zeroed, `res_valid_o` dropped. A config offered in the same cycle is not accepted.
- In-flight datapath results after a clear are ignored because their tags are gone.
- `cfg_chunks_i` > MAX_CHUNKS: the value is clamped to MAX_CHUNKS.

## Timing
- Reset values: `cfg_ready_o`=1, `in_ready_o`=0, `res_valid_o`=0, `res_data_o`=0, `res_ovf_o`=0, `dp_in_*_o`=0, tags=0.
- Config accepted at edge c → `in_ready_o` high from c. The first chunk can be accepted at edge c+1.
- Chunk accepted at edge t → `dp_in_*_o` valid after t. Its sums are accumulated at edge t+DP_LATENCY.
- Back-to-back job: chunks at c+1…c+N, `res_valid_o` high after edge c+N+DP_LATENCY.
- Bubbles delay completion by exactly one cycle each.
- N=0 job: `res_valid_o` high after edge c+1, with `res_data_o`=`cfg_corr_i`.
- Result handshake at edge r → `cfg_ready_o` high after r. The next config can be accepted at r+1.
- `in_valid_i` outside RUN is ignored. `in_ready_o` never depends combinationally on `in_valid_i`.

## Test plan
- All `in_0`=1, `in_1`=1, N=3, corr=−24, back-to-back → `res_data_o`=24 (16 per chunk), `res_ovf_o`=0, result valid exactly 3+3 cycles after config.
- Same job with random 0–3-cycle bubbles on `in_valid_i` → `res_data_o`=24, latency=6+bubbles.
- N=0, corr=−5 → `res_valid_o` the next cycle, `res_data_o`=−5, no chunk accepted.
- Hold `res_ready_i`=0 for 10 cycles → result stable, `cfg_ready_o`=0, `in_ready_o`=0 throughout.
- `clear_i` pulsed after 2 of 4 chunks, then a new job of all-ones with N=1, corr=−8 → result 8, no residue from the aborted job.
- corr=2^31−8, N=1, all ones (+16) → `res_data_o`=−2^31+8, `res_ovf_o`=1; the following job shows ovf=0.
